// File: rtl/fp32_mul_normround_if.sv
// Handshake bundle between the mantissa multiplier, the normalise/round stage
// and the result consumer.
interface fp32_mul_normround_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp_a;
   logic [7:0]  in_exp_b;
   logic [63:0] in_prod;
   logic [2:0]  in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   modport master (
      output in_valid, in_sign, in_exp_a, in_exp_b, in_prod, in_flags, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_sign, in_exp_a, in_exp_b, in_prod, in_flags, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fp32_mul_normround.sv
// Normalise, round-to-nearest-even and pack stage of the binary32 multiplier.
// Stage 1 normalises the mantissa product; stage 2 rounds and packs the result.
module fp32_mul_normround #(
   parameter int unsigned BIAS = 127,
   parameter logic [31:0] QNAN = 32'h7FC00000
) (
   input logic clk,
   input logic rst_n,
   fp32_mul_normround_if.slave bus
);

   // Valid/ready: a beat moves on any edge where valid & ready are both high;
   // valid and its data hold until accepted, ready may depend on the downstream ready.
   logic               s1_valid;
   logic               s1_sign;
   logic signed [10:0] s1_e;
   logic [22:0]        s1_mant;
   logic               s1_guard;
   logic               s1_sticky;
   logic [2:0]         s1_flags;

   logic               s2_valid;
   logic [31:0]        s2_result;
   logic [3:0]         s2_flags;

   logic               s1_adv;
   logic               in_ready_int;

   assign s1_adv       = !s2_valid || bus.out_ready;
   assign in_ready_int = !s1_valid || s1_adv;

   assign bus.in_ready   = in_ready_int;
   assign bus.out_valid  = s2_valid;
   assign bus.out_result = s2_result;
   assign bus.out_flags  = s2_flags;

   // Bits 63:48 of the product are always zero for 24x24-bit significands.
   logic unused_prod_hi;
   assign unused_prod_hi = ^bus.in_prod[63:48];

   logic signed [10:0] e_sum;
   logic signed [10:0] e_norm;
   logic [22:0]        n_mant;
   logic               n_guard;
   logic               n_sticky;

   always_comb begin
      e_sum    = $signed({3'b000, bus.in_exp_a} + {3'b000, bus.in_exp_b} - 11'(BIAS));
      e_norm   = e_sum;
      n_mant   = bus.in_prod[45:23];
      n_guard  = bus.in_prod[22];
      n_sticky = |bus.in_prod[21:0];
      if (bus.in_prod[47]) begin
         e_norm   = e_sum + 11'sd1;
         n_mant   = bus.in_prod[46:24];
         n_guard  = bus.in_prod[23];
         n_sticky = |bus.in_prod[22:0];
      end
   end

   logic               rnd;
   logic [23:0]        mant_sum;
   logic signed [10:0] e_rnd;
   logic [31:0]        pack_result;
   logic [3:0]         pack_flags;

   // A rounding carry leaves the sum at 1.000..., so the low 23 bits are already zero.
   always_comb begin
      rnd         = s1_guard && (s1_sticky || s1_mant[0]);
      mant_sum    = {1'b0, s1_mant} + {23'b0, rnd};
      e_rnd       = s1_e + $signed({10'b0, mant_sum[23]});
      pack_result = 32'h0;
      pack_flags  = 4'h0;
      if (s1_flags[2]) begin
         pack_result = QNAN;
         pack_flags  = 4'b1000;
      end else if (s1_flags[1]) begin
         pack_result = {s1_sign, 8'hFF, 23'b0};
      end else if (s1_flags[0]) begin
         pack_result = {s1_sign, 31'b0};
      end else if (e_rnd >= 11'sd255) begin
         pack_result = {s1_sign, 8'hFF, 23'b0};
         pack_flags  = 4'b0101;
      end else if (e_rnd <= 11'sd0) begin
         pack_result = {s1_sign, 31'b0};
         pack_flags  = 4'b0011;
      end else begin
         pack_result = {s1_sign, e_rnd[7:0], mant_sum[22:0]};
         pack_flags  = {3'b000, s1_guard || s1_sticky};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_sign   <= 1'b0;
         s1_e      <= 11'sd0;
         s1_mant   <= 23'h0;
         s1_guard  <= 1'b0;
         s1_sticky <= 1'b0;
         s1_flags  <= 3'h0;
         s2_valid  <= 1'b0;
         s2_result <= 32'h0;
         s2_flags  <= 4'h0;
      end else begin
         if (in_ready_int) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_sign   <= bus.in_sign;
               s1_e      <= e_norm;
               s1_mant   <= n_mant;
               s1_guard  <= n_guard;
               s1_sticky <= n_sticky;
               s1_flags  <= bus.in_flags;
            end
         end
         if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_result <= pack_result;
               s2_flags  <= pack_flags;
            end
         end
      end
   end

endmodule
